sme_bank_seq: RTL and testbench
===============================

// Module: sme_bank_seq
// PURPOSE
//  Context save/restore sequencer for the SME share banks 1..SMAX-1 (bank 0 = GPRs, not handled).
//  On start, walks every register (16) of each active bank, moving shares to/from memory over a
//  req/gnt memory port, driving the sme_state bank load/store interface. Used by trap/ctx-switch code.
// PARAMETERS
//  XLEN    32  data/address width
//  SMAX    4   max hardware shares; banks 1..SMAX-1 are sequenced
// PORTS
//  g_clk          in   1     global clock
//  g_reset        in   1     synchronous active-high reset
//  start_save     in   1     pulse: save banks to memory
//  start_restore  in   1     pulse: restore banks from memory
//  abort          in   1     terminate current sequence (flush)
//  base_addr      in   XLEN  memory base of save area, sampled on start
//  smectl_d       in   4     masks in use, sampled on start
//  busy           out  1     sequence in progress
//  done           out  1     1-cycle pulse: sequence finished (incl. error)
//  err            out  1     valid with done: memory error terminated sequence
//  aborted        out  1     1-cycle pulse: sequence terminated by abort
//  bank_sel       out  4     bank being accessed (drives smectl_b override)
//  bank_read      out  1     read share from bank_sel/bank_raddr
//  bank_raddr     out  4     bank register read address
//  bank_rdata     in   XLEN  bank read data (same cycle)
//  bank_wen       out  1     write bank_wdata to bank_sel/bank_waddr
//  bank_waddr     out  4     bank register write address
//  bank_wdata     out  XLEN  bank write data
//  mem_req        out  1     memory request
//  mem_gnt        in   1     request accepted this cycle
//  mem_wen        out  1     1=store, 0=load
//  mem_addr       out  XLEN  word address
//  mem_wdata      out  XLEN  store data (=bank_rdata)
//  mem_rsp_valid  in   1     load/store response
//  mem_rsp_err    in   1     response error
//  mem_rdata      in   XLEN  load data
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters 0.
//  - nbanks = min(smectl_d, SMAX-1). Order: reg 0..15 inner, bank 1..nbanks outer.
//  - mem_addr = {base_addr[XL:2],2'b0} + (((bank-1)*16+reg)<<2), modulo 2^XLEN (wraps).
//  - States: IDLE, SAVE_REQ, SAVE_RSP, LOAD_REQ, LOAD_RSP, FIN.
//  - IDLE: start_save -> SAVE_REQ; start_restore -> LOAD_REQ; both -> save wins; nbanks==0 -> FIN.
//    Starts while busy are ignored.
//  - SAVE_REQ: mem_req=mem_wen=1, bank_read=1, mem_wdata=bank_rdata; on mem_gnt -> SAVE_RSP.
//  - SAVE_RSP: wait mem_rsp_valid; err -> FIN(err=1); else advance; last -> FIN, else SAVE_REQ.
//  - LOAD_REQ: mem_req=1, mem_wen=0; on mem_gnt -> LOAD_RSP.
//  - LOAD_RSP: on mem_rsp_valid && !err: bank_wen=1, bank_wdata=mem_rdata, same cycle; advance.
//  - One outstanding access max; min 2 cycles/word; done asserted in FIN, then IDLE.
//  - d=1, immediate gnt/rsp: 16 words = 32 cycles + 1 FIN cycle.
//  - mem_req, once raised, held with stable addr/data until mem_gnt (no retraction except abort).
//  - abort in *_REQ without gnt same cycle: drop req, -> IDLE, aborted=1.
//    abort coincident with gnt, or in *_RSP: wait for response (no bank write), then IDLE, aborted=1.
//    No done on abort.
//  - busy = (state != IDLE); bank_sel=0 when idle.
//  - Reset mid-sequence: immediate IDLE; outstanding memory response is ignored.
// STRUCTURE
//  - sme_pkg: typedef enum sme_seq_state_t; localparam SME_NREGS=16.
//  - Single module; reg/bank counters and address adder inline, no sub-module.
// TESTING
//  1 d=3,SMAX=4,base=0x1000, gnt/rsp immediate, save
//    -> 48 stores 0x1000..0x10BC, bank_sel 1,2,3; done at cycle 97.
//  2 restore after save with randomized gnt/rsp delays (0-5)
//    -> bank contents match, 48 bank_wen pulses, err=0.
//  3 d=0 start_save -> done cycle 1, no mem_req, busy high exactly 1 cycle.
//  4 mem_rsp_err on 5th load -> done+err, 4 bank writes only, no further mem_req.
//  5 abort in LOAD_RSP at word 7 -> no bank_wen for word 7, aborted after rsp, no done.
//  6 base=0xFFFFFFF8,d=1 save -> addrs wrap 0xFFFFFFF8,0xFFFFFFFC,0x0..0x34; start during busy ignored.

Source files
------------

// File: rtl/sme_bank_seq_pkg.sv
// Shared types for the SME share-bank save/restore sequencer.
package sme_bank_seq_pkg;

  localparam int SME_NREGS = 16;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_SAVE_REQ,
    SEQ_SAVE_RSP,
    SEQ_LOAD_REQ,
    SEQ_LOAD_RSP,
    SEQ_FIN
  } sme_seq_state_t;

endpackage

// File: rtl/sme_bank_seq_if.sv
// Control, bank load/store and memory-port signals of the bank sequencer.
interface sme_bank_seq_if #(
  parameter int XLEN = 32
);
  logic            start_save;
  logic            start_restore;
  logic            abort;
  logic [XLEN-1:0] base_addr;
  logic [3:0]      smectl_d;
  logic            busy;
  logic            done;
  logic            err;
  logic            aborted;

  logic [3:0]      bank_sel;
  logic            bank_read;
  logic [3:0]      bank_raddr;
  logic [XLEN-1:0] bank_rdata;
  logic            bank_wen;
  logic [3:0]      bank_waddr;
  logic [XLEN-1:0] bank_wdata;

  logic            mem_req;
  logic            mem_gnt;
  logic            mem_wen;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rsp_valid;
  logic            mem_rsp_err;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    input  start_save, start_restore, abort, base_addr, smectl_d,
    input  bank_rdata, mem_gnt, mem_rsp_valid, mem_rsp_err, mem_rdata,
    output busy, done, err, aborted,
    output bank_sel, bank_read, bank_raddr, bank_wen, bank_waddr, bank_wdata,
    output mem_req, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    output start_save, start_restore, abort, base_addr, smectl_d,
    output bank_rdata, mem_gnt, mem_rsp_valid, mem_rsp_err, mem_rdata,
    input  busy, done, err, aborted,
    input  bank_sel, bank_read, bank_raddr, bank_wen, bank_waddr, bank_wdata,
    input  mem_req, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sme_bank_seq.sv
// Walks the 16 registers of share banks 1..nbanks, storing them to or loading them
// from memory one word at a time over a req/gnt port with a single outstanding access.
//   state    | meaning
//   IDLE     | waiting for start_save / start_restore
//   SAVE_REQ | store request held until granted (bank read same cycle)
//   SAVE_RSP | waiting for store response
//   LOAD_REQ | load request held until granted
//   LOAD_RSP | waiting for load data, written to the bank on arrival
//   FIN      | done pulse (err valid), back to IDLE
module sme_bank_seq
  import sme_bank_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SMAX = 4
) (
  input  logic           g_clk,
  input  logic           g_reset,
  sme_bank_seq_if.master bus
);

  localparam logic [3:0]      MAX_BANK  = 4'(SMAX - 1);
  localparam logic [3:0]      LAST_REG  = 4'(SME_NREGS - 1);
  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  sme_seq_state_t  r_state, w_state_nxt;
  logic [3:0]      r_reg, r_bank, r_nbanks;
  logic [XLEN-1:0] r_base;
  logic            r_err, r_abort_pend;

  logic [3:0]      w_nbanks;
  logic            w_start, w_last, w_advance, w_err_set, w_abort_set;
  logic [XLEN-1:0] w_idx, w_addr;

  logic            w_done, w_err, w_aborted;
  logic [3:0]      w_bank_sel, w_bank_raddr, w_bank_waddr;
  logic            w_bank_read, w_bank_wen;
  logic [XLEN-1:0] w_bank_wdata;
  logic            w_mem_req, w_mem_wen;
  logic [XLEN-1:0] w_mem_addr, w_mem_wdata;

  assign w_nbanks = (bus.smectl_d > MAX_BANK) ? MAX_BANK : bus.smectl_d;
  assign w_start  = (r_state == SEQ_IDLE) && (bus.start_save || bus.start_restore);
  assign w_last   = (r_reg == LAST_REG) && (r_bank == r_nbanks);
  // Word index (bank-1)*16+reg is just the concatenation of the two counters.
  assign w_idx    = XLEN'({r_bank - 4'd1, r_reg});
  assign w_addr   = (r_base & WORD_MASK) + (w_idx << 2);

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_reg        <= '0;
      r_bank       <= '0;
      r_nbanks     <= '0;
      r_base       <= '0;
      r_err        <= 1'b0;
      r_abort_pend <= 1'b0;
    end else if (w_start) begin
      r_reg        <= '0;
      r_bank       <= 4'd1;
      r_nbanks     <= w_nbanks;
      r_base       <= bus.base_addr;
      r_err        <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_advance) begin
        if (r_reg == LAST_REG) begin
          r_reg  <= '0;
          r_bank <= r_bank + 4'd1;
        end else begin
          r_reg <= r_reg + 4'd1;
        end
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_abort_set) begin
        r_abort_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_advance    = 1'b0;
    w_err_set    = 1'b0;
    w_abort_set  = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_aborted    = 1'b0;
    w_bank_sel   = '0;
    w_bank_read  = 1'b0;
    w_bank_raddr = '0;
    w_bank_wen   = 1'b0;
    w_bank_waddr = '0;
    w_bank_wdata = '0;
    w_mem_req    = 1'b0;
    w_mem_wen    = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;

    unique case (r_state)
      SEQ_IDLE: begin
        if (bus.start_save) begin
          w_state_nxt = (w_nbanks == 4'd0) ? SEQ_FIN : SEQ_SAVE_REQ;
        end else if (bus.start_restore) begin
          w_state_nxt = (w_nbanks == 4'd0) ? SEQ_FIN : SEQ_LOAD_REQ;
        end
      end

      SEQ_SAVE_REQ, SEQ_LOAD_REQ: begin
        w_mem_req  = 1'b1;
        w_mem_wen  = (r_state == SEQ_SAVE_REQ);
        w_mem_addr = w_addr;
        w_bank_sel = r_bank;
        if (r_state == SEQ_SAVE_REQ) begin
          w_bank_read  = 1'b1;
          w_bank_raddr = r_reg;
          w_mem_wdata  = bus.bank_rdata;
        end
        // Once granted the access is committed, so an abort must wait for its response.
        if (bus.mem_gnt) begin
          w_state_nxt = (r_state == SEQ_SAVE_REQ) ? SEQ_SAVE_RSP : SEQ_LOAD_RSP;
          w_abort_set = bus.abort;
        end else if (bus.abort) begin
          w_state_nxt = SEQ_IDLE;
          w_aborted   = 1'b1;
        end
      end

      SEQ_SAVE_RSP, SEQ_LOAD_RSP: begin
        w_bank_sel  = r_bank;
        w_abort_set = bus.abort;
        if (bus.mem_rsp_valid) begin
          if (r_abort_pend || bus.abort) begin
            w_state_nxt = SEQ_IDLE;
            w_aborted   = 1'b1;
          end else if (bus.mem_rsp_err) begin
            w_err_set   = 1'b1;
            w_state_nxt = SEQ_FIN;
          end else begin
            w_advance = 1'b1;
            if (r_state == SEQ_LOAD_RSP) begin
              w_bank_wen   = 1'b1;
              w_bank_waddr = r_reg;
              w_bank_wdata = bus.mem_rdata;
            end
            if (w_last) begin
              w_state_nxt = SEQ_FIN;
            end else begin
              w_state_nxt = (r_state == SEQ_SAVE_RSP) ? SEQ_SAVE_REQ : SEQ_LOAD_REQ;
            end
          end
        end
      end

      SEQ_FIN: begin
        w_done      = 1'b1;
        w_err       = r_err;
        w_state_nxt = SEQ_IDLE;
      end

      default: begin
        w_state_nxt = SEQ_IDLE;
      end
    endcase
  end

  assign bus.busy       = (r_state != SEQ_IDLE);
  assign bus.done       = w_done;
  assign bus.err        = w_err;
  assign bus.aborted    = w_aborted;
  assign bus.bank_sel   = w_bank_sel;
  assign bus.bank_read  = w_bank_read;
  assign bus.bank_raddr = w_bank_raddr;
  assign bus.bank_wen   = w_bank_wen;
  assign bus.bank_waddr = w_bank_waddr;
  assign bus.bank_wdata = w_bank_wdata;
  assign bus.mem_req    = w_mem_req;
  assign bus.mem_wen    = w_mem_wen;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;

endmodule

// File: tb/tb_sme_bank_seq.sv
// Bench for sme_bank_seq: table of save/restore runs, randomized rounds and
// hand-written error, abort and address-wrap sequences against a word-list model.
`timescale 1ns/1ps
module tb_sme_bank_seq;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  bank;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    bit          restore;
    logic [31:0] base;
    logic [3:0]  d;
    int          ghi;
    int          rhi;
    int          words;
    int          rel;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sme_bank_seq_if #(.XLEN(32)) bus();
  sme_bank_seq #(.XLEN(32), .SMAX(4)) dut (.g_clk(clk), .g_reset(rst), .bus(bus));

  acc_t        exp_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] bank_q [16][16];
  logic [31:0] snap   [16][16];
  logic [31:0] mem [logic [31:0]];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, abt_cyc = 0, rsp_cyc = 0;
  int n_acc = 0, n_wen = 0, n_done = 0, n_abt = 0, n_busy = 0;
  logic err_seen = 1'b0;
  int gnt_lo = 0, gnt_hi = 0, rsp_lo = 0, rsp_hi = 0, err_idx = -1;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.bank_rdata = bank_q[bus.bank_sel][bus.bank_raddr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Memory responder: one outstanding access, randomized grant/response latency.
  initial begin
    bit          pending;
    bit          waiting;
    int          gnt_cnt, rsp_cnt;
    logic [31:0] p_addr;
    pending = 0; waiting = 0; gnt_cnt = 0; rsp_cnt = 0; p_addr = '0;
    bus.mem_gnt = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_err = 0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_gnt = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_err = 0; bus.mem_rdata = '0;
      if (pending) begin
        if (rsp_cnt == 0) begin
          bus.mem_rsp_valid = 1;
          bus.mem_rsp_err   = (n_acc == err_idx);
          bus.mem_rdata     = mem.exists(p_addr) ? mem[p_addr] : (32'hBAD0_0000 ^ p_addr);
          pending = 0;
        end else begin
          rsp_cnt--;
        end
      end else if (bus.mem_req) begin
        if (!waiting) begin
          waiting = 1;
          gnt_cnt = $urandom_range(gnt_hi, gnt_lo);
        end
        if (gnt_cnt == 0) begin
          bus.mem_gnt = 1;
          waiting = 0;
          pending = 1;
          p_addr  = bus.mem_addr;
          rsp_cnt = $urandom_range(rsp_hi, rsp_lo);
        end else begin
          gnt_cnt--;
        end
      end else begin
        waiting = 0;
      end
    end
  end

  // Monitor: samples settled outputs ahead of the clock edge that commits them.
  initial begin
    acc_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.busy) n_busy++;
      if (bus.mem_rsp_valid) rsp_cyc = cyc;
      if (bus.mem_req && bus.mem_gnt) begin
        n_acc++;
        acc_log.push_back(bus.mem_addr);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("acc_addr", bus.mem_addr, e.addr);
          check("acc_wen", 32'(bus.mem_wen), 32'(e.wen));
          check("acc_bank", 32'(bus.bank_sel), 32'(e.bank));
          if (e.wen) check("acc_wdata", bus.mem_wdata, e.data);
        end
        if (bus.mem_wen) mem[bus.mem_addr] = bus.mem_wdata;
      end
      if (bus.bank_wen) begin
        n_wen++;
        bank_q[bus.bank_sel][bus.bank_waddr] = bus.bank_wdata;
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
        err_seen = bus.err;
      end
      if (bus.aborted) begin
        n_abt++;
        abt_cyc = cyc;
      end
    end
  end

  task automatic fill_banks(input bit keep_snap);
    for (int b = 0; b < 16; b++)
      for (int r = 0; r < 16; r++)
        bank_q[b][r] = $urandom;
    if (keep_snap) snap = bank_q;
  endtask

  task automatic start_run(input bit restore, input logic [31:0] base, input logic [3:0] d);
    int   nb;
    acc_t a;
    nb = (d > 4'd3) ? 3 : int'(d);
    exp_q.delete();
    acc_log.delete();
    for (int b = 1; b <= nb; b++)
      for (int r = 0; r < 16; r++) begin
        a.addr = (base & 32'hFFFF_FFFC) + 32'(((b - 1) * 16 + r) * 4);
        a.wen  = !restore;
        a.bank = 4'(b);
        a.data = bank_q[b][r];
        exp_q.push_back(a);
      end
    n_acc = 0; n_wen = 0; n_done = 0; n_abt = 0; n_busy = 0; err_seen = 0;
    @(negedge clk);
    bus.base_addr = base;
    bus.smectl_d  = d;
    if (restore) bus.start_restore = 1; else bus.start_save = 1;
    start_cyc = cyc;
    @(negedge clk);
    bus.start_save    = 0;
    bus.start_restore = 0;
    bus.base_addr     = $urandom;
    bus.smectl_d      = 4'($urandom_range(15, 0));
  endtask

  task automatic wait_end();
    for (int i = 0; i < 4000; i++) begin
      if (n_done != 0 || n_abt != 0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic end_checks(input int words, input int wens, input int rel);
    check("done_cnt", n_done, 1);
    check("err", 32'(err_seen), 0);
    check("abort_cnt", n_abt, 0);
    check("acc_cnt", n_acc, words);
    check("wen_cnt", n_wen, wens);
    check("busy_end", 32'(bus.busy), 0);
    if (rel >= 0) begin
      check("done_cycle", done_cyc - start_cyc, rel);
      check("busy_cycles", n_busy, rel);
    end
  endtask

  task automatic bank_cmp(input int nb);
    int bad;
    for (int b = 1; b <= nb; b++) begin
      bad = 0;
      for (int r = 0; r < 16; r++)
        if (bank_q[b][r] !== snap[b][r]) bad++;
      check($sformatf("bank%0d_restore", b), bad, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[7];
    logic [31:0] keep;
    int          bad;
    vt[0] = '{0, 32'h0000_1000, 4'd3,  0, 0, 48, 97};
    vt[1] = '{1, 32'h0000_1000, 4'd3,  5, 5, 48, -1};
    vt[2] = '{0, 32'h0000_2000, 4'd0,  0, 0,  0,  1};
    vt[3] = '{0, 32'h0000_3002, 4'd15, 2, 3, 48, -1};
    vt[4] = '{1, 32'h0000_3002, 4'd7,  0, 0, 48, 97};
    vt[5] = '{0, 32'h0000_0040, 4'd1,  0, 0, 16, 33};
    vt[6] = '{0, 32'h0000_0500, 4'd2,  3, 1, 32, -1};

    bus.start_save = 0; bus.start_restore = 0; bus.abort = 0;
    bus.base_addr = '0; bus.smectl_d = '0;
    fill_banks(1);
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_bank_sel", 32'(bus.bank_sel), 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      gnt_lo = 0; gnt_hi = vt[i].ghi; rsp_lo = 0; rsp_hi = vt[i].rhi;
      fill_banks(!vt[i].restore);
      start_run(vt[i].restore, vt[i].base, vt[i].d);
      wait_end();
      end_checks(vt[i].words, vt[i].restore ? vt[i].words : 0, vt[i].rel);
      if (vt[i].restore) bank_cmp(vt[i].words / 16);
    end

    for (int k = 0; k < 4; k++) begin
      logic [31:0] rb;
      logic [3:0]  rd;
      int          w;
      rb = $urandom;
      rd = 4'($urandom_range(15, 0));
      w  = ((rd > 4'd3) ? 3 : int'(rd)) * 16;
      gnt_lo = 0; gnt_hi = $urandom_range(5, 0); rsp_lo = 0; rsp_hi = $urandom_range(5, 0);
      fill_banks(1);
      start_run(0, rb, rd);
      wait_end();
      end_checks(w, 0, -1);
      fill_banks(0);
      start_run(1, rb, rd);
      wait_end();
      end_checks(w, w, -1);
      bank_cmp(w / 16);
    end

    // Memory error on the 5th load ends the restore with err after 4 bank writes.
    gnt_lo = 0; gnt_hi = 3; rsp_lo = 0; rsp_hi = 3;
    fill_banks(1);
    start_run(0, 32'h0000_8000, 4'd1);
    wait_end();
    end_checks(16, 0, -1);
    fill_banks(0);
    err_idx = 5;
    start_run(1, 32'h0000_8000, 4'd1);
    wait_end();
    check("errrun_done", n_done, 1);
    check("errrun_err", 32'(err_seen), 1);
    check("errrun_wen", n_wen, 4);
    check("errrun_acc", n_acc, 5);
    bad = 0;
    for (int r = 0; r < 4; r++) if (bank_q[1][r] !== snap[1][r]) bad++;
    check("errrun_data", bad, 0);
    repeat (10) @(negedge clk);
    check("errrun_no_req", n_acc, 5);
    check("errrun_idle", 32'(bus.busy), 0);
    err_idx = -1;

    // Abort while the load of word 7 is outstanding.
    gnt_lo = 0; gnt_hi = 0; rsp_lo = 0; rsp_hi = 0;
    fill_banks(1);
    start_run(0, 32'h0000_9000, 4'd1);
    wait_end();
    end_checks(16, 0, -1);
    fill_banks(0);
    keep = bank_q[1][7];
    rsp_lo = 2; rsp_hi = 2;
    start_run(1, 32'h0000_9000, 4'd1);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (n_acc >= 8) break;
    end
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    wait_end();
    check("abtrsp_aborted", n_abt, 1);
    check("abtrsp_done", n_done, 0);
    check("abtrsp_wen", n_wen, 7);
    check("abtrsp_acc", n_acc, 8);
    check("abtrsp_at_rsp", abt_cyc, rsp_cyc);
    check("abtrsp_word7", bank_q[1][7], keep);
    check("abtrsp_word6", bank_q[1][6], snap[1][6]);
    check("abtrsp_idle", 32'(bus.busy), 0);

    // Abort while a store request is still waiting for its grant.
    gnt_lo = 3; gnt_hi = 3; rsp_lo = 0; rsp_hi = 0;
    start_run(0, 32'h0000_A000, 4'd2);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    wait_end();
    check("abtreq_aborted", n_abt, 1);
    check("abtreq_acc", n_acc, 0);
    check("abtreq_done", n_done, 0);
    check("abtreq_idle", 32'(bus.busy), 0);

    // Save area at the top of the address space wraps to 0; starts while busy are ignored.
    gnt_lo = 0; gnt_hi = 2; rsp_lo = 0; rsp_hi = 2;
    fill_banks(1);
    start_run(0, 32'hFFFF_FFF8, 4'd1);
    repeat (5) @(negedge clk);
    bus.start_restore = 1; bus.start_save = 1; bus.smectl_d = 4'd3;
    @(negedge clk);
    bus.start_restore = 0; bus.start_save = 0;
    wait_end();
    end_checks(16, 0, -1);
    check("wrap_log_cnt", acc_log.size(), 16);
    if (acc_log.size() == 16) begin
      check("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
      check("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
      check("wrap_addr2", acc_log[2], 32'h0000_0000);
      check("wrap_addr15", acc_log[15], 32'h0000_0034);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
